// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: WIDTH iterations, MSB first, start/done handshake.
// Optional macro DIV_ZERO_FASTPATH_EN: a zero divisor finishes on the accepting edge with div_by_zero=1.
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH-1:0] partial_reg;
  logic [WIDTH-1:0] divisor_reg;
  // Dividend bits shift out of the MSB while quotient bits shift into the LSB.
  logic [WIDTH-1:0] shift_reg;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             q_bit;
  logic [WIDTH-1:0] partial_next;
  logic [WIDTH-1:0] shift_next;

  always_comb begin
    shifted      = {partial_reg, shift_reg[WIDTH-1]};
    trial        = shifted - {1'b0, divisor_reg};
    q_bit        = ~trial[WIDTH];
    // A restored partial is always below the divisor, so it fits in WIDTH bits.
    partial_next = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    shift_next   = {shift_reg[WIDTH-2:0], q_bit};
  end

`ifdef DIV_ZERO_FASTPATH_EN
  logic div_by_zero_reg;
  assign div_by_zero = div_by_zero_reg;
`else
  assign div_by_zero = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      partial_reg <= '0;
      divisor_reg <= '0;
      shift_reg   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
`ifdef DIV_ZERO_FASTPATH_EN
      div_by_zero_reg <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            shift_reg   <= dividend;
            divisor_reg <= divisor;
            count_reg   <= CW'(WIDTH - 1);
            partial_reg <= '0;
`ifdef DIV_ZERO_FASTPATH_EN
            if (divisor == '0) begin
              state_reg       <= DONE;
              done            <= 1'b1;
              quotient        <= '1;
              remainder       <= dividend;
              div_by_zero_reg <= 1'b1;
            end else begin
              state_reg <= RUN;
              busy      <= 1'b1;
            end
`else
            state_reg <= RUN;
            busy      <= 1'b1;
`endif
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          partial_reg <= partial_next;
          shift_reg   <= shift_next;
          if (count_reg == '0) begin
            state_reg <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= shift_next;
            remainder <= partial_next;
`ifdef DIV_ZERO_FASTPATH_EN
            div_by_zero_reg <= 1'b0;
`endif
          end else begin
            count_reg <= count_reg - 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider (WIDTH=8): latency, edge values, divide-by-zero, handshake, reset.
module tb_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int tests = 0;
  int fails = 0;

  restoring_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Issue one request from idle and wait (bounded) for done; lat counts edges after the accept edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int bcnt, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic dz, output logic single,
                        output logic held);
    logic [W-1:0] q0;
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0; bcnt = 0; held = 1'b1; q0 = quotient;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (quotient !== q0) held = 1'b0;
      @(negedge clk);
      lat++;
    end
    q = quotient; r = remainder; dz = div_by_zero;
    @(negedge clk);
    single = !done && !busy;
    $display("[TB] op %0d/%0d -> q=%0d r=%0d dz=%0d lat=%0d busy_cycles=%0d", a, b, q, r, dz, lat, bcnt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    #12;
    tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got busy=%0b done=%0b q=%0d r=%0d dz=%0b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bc; logic [W-1:0] q, r; logic dz, single, held;
    run_op(8'd100, 8'd7, lat, bc, q, r, dz, single, held);
    tests++;
    if ({q, r} !== {8'd14, 8'd2}) begin
      fails++; $display("FAIL basic_result: got q=%0d r=%0d, want q=14 r=2", q, r);
    end
    tests++;
    if (lat !== 8 || bc !== 8) begin
      fails++; $display("FAIL basic_timing: got lat=%0d busy=%0d, want 8/8", lat, bc);
    end
    tests++;
    if (!single || !held || dz !== 1'b0) begin
      fails++; $display("FAIL basic_pulse: got single=%0b held=%0b dz=%0b, want 1 1 0", single, held, dz);
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] ta [3] = '{8'd255, 8'd5, 8'd0};
    logic [W-1:0] tb [3] = '{8'd1,   8'd9, 8'd3};
    logic [W-1:0] tq [3] = '{8'd255, 8'd0, 8'd0};
    logic [W-1:0] tr [3] = '{8'd0,   8'd5, 8'd0};
    for (int i = 0; i < 3; i++) begin
      int lat, bc; logic [W-1:0] q, r; logic dz, single, held;
      run_op(ta[i], tb[i], lat, bc, q, r, dz, single, held);
      tests++;
      if ({q, r} !== {tq[i], tr[i]} || lat !== 8 || !single) begin
        fails++;
        $display("FAIL edge_%0d: got q=%0d r=%0d lat=%0d single=%0b, want q=%0d r=%0d lat=8 single=1",
                 i, q, r, lat, single, tq[i], tr[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc; logic [W-1:0] q, r; logic dz, single, held;
    int exp_lat; logic exp_dz;
`ifdef DIV_ZERO_FASTPATH_EN
    exp_lat = 0; exp_dz = 1'b1;
`else
    exp_lat = 8; exp_dz = 1'b0;
`endif
    run_op(8'd77, 8'd0, lat, bc, q, r, dz, single, held);
    tests++;
    if ({q, r} !== {8'd255, 8'd77}) begin
      fails++; $display("FAIL div_zero_result: got q=%0d r=%0d, want q=255 r=77", q, r);
    end
    tests++;
    if (lat !== exp_lat || bc !== exp_lat || dz !== exp_dz || !single) begin
      fails++;
      $display("FAIL div_zero_timing: got lat=%0d busy=%0d dz=%0b single=%0b, want lat=%0d busy=%0d dz=%0b single=1",
               lat, bc, dz, single, exp_lat, exp_lat, exp_dz);
    end
  endtask

  task automatic test_ignore_start();
    int k;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 0;
    repeat (3) begin @(negedge clk); k++; end
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk); k++;
    start = 1'b0; dividend = 8'd9; divisor = 8'd2;
    while (!done && k < 40) begin @(negedge clk); k++; end
    $display("[TB] ignore_start 100/7 -> q=%0d r=%0d lat=%0d", quotient, remainder, k);
    tests++;
    if ({quotient, remainder} !== {8'd14, 8'd2} || k !== 8) begin
      fails++; $display("FAIL ignore_start: got q=%0d r=%0d lat=%0d, want q=14 r=2 lat=8", quotient, remainder, k);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; k = 0;
    @(negedge clk); k++;
    start = 1'b1; dividend = 8'd200; divisor = 8'd13;
    while (!done && k < 40) begin @(negedge clk); k++; end
    $display("[TB] b2b first 100/7 -> q=%0d r=%0d lat=%0d", quotient, remainder, k);
    tests++;
    if ({quotient, remainder} !== {8'd14, 8'd2} || k !== 8) begin
      fails++; $display("FAIL b2b_first: got q=%0d r=%0d lat=%0d, want q=14 r=2 lat=8", quotient, remainder, k);
    end
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      fails++; $display("FAIL b2b_accept: got busy=%0b done=%0b, want busy=1 done=0", busy, done);
    end
    k = 0;
    while (!done && k < 40) begin @(negedge clk); k++; end
    $display("[TB] b2b second 200/13 -> q=%0d r=%0d lat=%0d", quotient, remainder, k);
    tests++;
    if ({quotient, remainder} !== {8'd15, 8'd5} || k !== 8) begin
      fails++; $display("FAIL b2b_second: got q=%0d r=%0d lat=%0d, want q=15 r=5 lat=8", quotient, remainder, k);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int seen;
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      fails++;
      $display("FAIL reset_midrun: got busy=%0b done=%0b q=%0d r=%0d dz=%0b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (done || busy) seen++; end
    $display("[TB] reset_midrun aborted, activity after release=%0d", seen);
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL reset_no_done: got %0d active cycles, want 0", seen);
    end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 150; i++) begin
      int lat, bc; logic [W-1:0] q, r; logic dz, single, held;
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(1, 255));
      run_op(a, b, lat, bc, q, r, dz, single, held);
      tests++;
      if ((16'(q) * 16'(b) + 16'(r)) !== 16'(a) || r >= b || lat !== 8) begin
        fails++;
        $display("FAIL sweep_%0d: %0d/%0d got q=%0d r=%0d lat=%0d, want q=%0d r=%0d lat=8",
                 i, a, b, q, r, lat, a / b, a % b);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
